// File: rtl/fetch_decode_ctrl.sv
// Program counter, instruction register and decode stage feeding the register file.
// Each instruction takes two cycles: FETCH latches the word, DECODE presents registered controls.
module fetch_decode_ctrl #(
  parameter int PC_W = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            zero_in,
  input  logic [8:0]      instr_in,
  output logic [PC_W-1:0] instr_addr,
  output logic [2:0]      reg_dest,
  output logic [2:0]      reg_src,
  output logic [2:0]      reg_write,
  output logic [7:0]      immediate,
  output logic            mode,
  output logic            lea,
  output logic            write_enable,
  output logic            regToReg,
  output logic            memToReg,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {IDLE, FETCH, DECODE, HALTED} state_t;

  localparam logic [2:0] OP_MOV  = 3'b000;
  localparam logic [2:0] OP_MOVI = 3'b001;
  localparam logic [2:0] OP_LD   = 3'b010;
  localparam logic [2:0] OP_LEA  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_BNZ  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  // Branch arithmetic is done at least 6 bits wide so narrow PCs still wrap correctly.
  localparam int EW = (PC_W > 6) ? PC_W : 6;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [8:0]      ir_q, ir_d;
  logic [2:0]      reg_dest_q, reg_dest_d;
  logic [2:0]      reg_src_q, reg_src_d;
  logic [2:0]      reg_write_q, reg_write_d;
  logic [7:0]      immediate_q, immediate_d;
  logic            mode_q, mode_d;
  logic            lea_q, lea_d;
  logic            write_enable_q, write_enable_d;
  logic            reg_to_reg_q, reg_to_reg_d;
  logic            mem_to_reg_q, mem_to_reg_d;

  logic [2:0]      fetch_op;
  logic [EW-1:0]   off_ext;
  logic [EW-1:0]   branch_sum;
  logic [PC_W-1:0] pc_inc;

  assign fetch_op   = instr_in[8:6];
  assign off_ext    = EW'($signed(ir_q[5:0]));
  assign branch_sum = EW'(pc_q) + off_ext;
  assign pc_inc     = pc_q + PC_W'(1);

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    ir_d           = ir_q;
    reg_dest_d     = 3'd0;
    reg_src_d      = 3'd0;
    reg_write_d    = 3'd0;
    immediate_d    = 8'd0;
    mode_d         = 1'b0;
    lea_d          = 1'b0;
    write_enable_d = 1'b0;
    reg_to_reg_d   = 1'b0;
    mem_to_reg_d   = 1'b0;

    case (state_q)
      IDLE, HALTED: begin
        if (start) begin
          state_d = FETCH;
          pc_d    = '0;
        end
      end
      FETCH: begin
        // Controls are decoded from the ROM word now so they are registered for DECODE.
        ir_d        = instr_in;
        state_d     = DECODE;
        reg_dest_d  = instr_in[5:3];
        reg_write_d = instr_in[5:3];
        reg_src_d   = instr_in[2:0];
        immediate_d = {5'b0, instr_in[2:0]};
        case (fetch_op)
          OP_MOV:  begin reg_to_reg_d = 1'b1; write_enable_d = 1'b1; end
          OP_MOVI: begin reg_to_reg_d = 1'b1; mode_d = 1'b1; write_enable_d = 1'b1; end
          OP_LD:   begin mem_to_reg_d = 1'b1; write_enable_d = 1'b1; end
          OP_LEA:  begin lea_d = 1'b1; write_enable_d = 1'b1; end
          OP_ADD, OP_SUB: write_enable_d = 1'b1;
          default: ;
        endcase
      end
      DECODE: begin
        state_d = FETCH;
        case (ir_q[8:6])
          OP_BNZ:  pc_d = zero_in ? pc_inc : branch_sum[PC_W-1:0];
          OP_HALT: state_d = HALTED;
          default: pc_d = pc_inc;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      pc_q           <= '0;
      ir_q           <= '0;
      reg_dest_q     <= '0;
      reg_src_q      <= '0;
      reg_write_q    <= '0;
      immediate_q    <= '0;
      mode_q         <= 1'b0;
      lea_q          <= 1'b0;
      write_enable_q <= 1'b0;
      reg_to_reg_q   <= 1'b0;
      mem_to_reg_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      ir_q           <= ir_d;
      reg_dest_q     <= reg_dest_d;
      reg_src_q      <= reg_src_d;
      reg_write_q    <= reg_write_d;
      immediate_q    <= immediate_d;
      mode_q         <= mode_d;
      lea_q          <= lea_d;
      write_enable_q <= write_enable_d;
      reg_to_reg_q   <= reg_to_reg_d;
      mem_to_reg_q   <= mem_to_reg_d;
    end
  end

  assign instr_addr   = pc_q;
  assign reg_dest     = reg_dest_q;
  assign reg_src      = reg_src_q;
  assign reg_write    = reg_write_q;
  assign immediate    = immediate_q;
  assign mode         = mode_q;
  assign lea          = lea_q;
  assign write_enable = write_enable_q;
  assign regToReg     = reg_to_reg_q;
  assign memToReg     = mem_to_reg_q;
  assign busy         = (state_q == FETCH) || (state_q == DECODE);
  assign done         = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Self-checking bench: directed programs plus a random program, checked instruction by
// instruction against an ISA-level model (program counter + ROM + per-opcode control table).
module tb_fetch_decode_ctrl;
  localparam int W  = 10;
  localparam int W4 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0, zero_in = 1'b0;
  logic [8:0] instr_in;
  logic [W-1:0] instr_addr;
  logic [2:0] reg_dest, reg_src, reg_write;
  logic [7:0] immediate;
  logic mode, lea, write_enable, regToReg, memToReg, busy, done;
  logic [21:0] ctrl_all;

  logic start4 = 1'b0, zero4 = 1'b0;
  logic [8:0] instr4;
  logic [W4-1:0] addr4;
  logic [2:0] s_dest, s_src, s_write;
  logic [7:0] s_imm;
  logic s_mode, s_lea, s_we, s_rtr, s_m2r, s_busy, s_done;

  logic [8:0] rom  [1024];
  logic [8:0] rom4 [16];

  int n_pass = 0, n_total = 0;
  int mpc;
  bit mhalt;

  assign instr_in = rom[instr_addr];
  assign instr4   = rom4[addr4];
  assign ctrl_all = {reg_dest, reg_src, reg_write, immediate, mode, lea, write_enable, regToReg, memToReg};

  fetch_decode_ctrl #(.PC_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .zero_in(zero_in), .instr_in(instr_in),
    .instr_addr(instr_addr), .reg_dest(reg_dest), .reg_src(reg_src), .reg_write(reg_write),
    .immediate(immediate), .mode(mode), .lea(lea), .write_enable(write_enable),
    .regToReg(regToReg), .memToReg(memToReg), .busy(busy), .done(done));

  fetch_decode_ctrl #(.PC_W(W4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .zero_in(zero4), .instr_in(instr4),
    .instr_addr(addr4), .reg_dest(s_dest), .reg_src(s_src), .reg_write(s_write),
    .immediate(s_imm), .mode(s_mode), .lea(s_lea), .write_enable(s_we),
    .regToReg(s_rtr), .memToReg(s_m2r), .busy(s_busy), .done(s_done));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected DECODE-cycle control word for one instruction, from the opcode table.
  function automatic logic [21:0] exp_ctrl(input logic [8:0] ins);
    int op = int'(ins[8:6]);
    logic we  = (op <= 5);
    logic md  = (op == 1);
    logic le  = (op == 3);
    logic rtr = (op <= 1);
    logic m2r = (op == 2);
    return {ins[5:3], ins[2:0], ins[5:3], {5'b0, ins[2:0]}, md, le, we, rtr, m2r};
  endfunction

  function automatic int wrap(input int v, input int w);
    int m = 1 << w;
    return ((v % m) + m) % m;
  endfunction

  // sp: 0 = no start pulse, 1 = pulse during FETCH, 2 = pulse during DECODE.
  task automatic run_instr(input bit zr, input int sp);
    logic [8:0] ins;
    int off;
    check("fetch_busy", busy, 1);
    check("fetch_addr", instr_addr, mpc);
    check("fetch_ctrl_zero", ctrl_all, 0);
    start = (sp == 1);
    @(negedge clk);
    start = 1'b0;
    ins = rom[mpc];
    check("decode_ctrl", ctrl_all, exp_ctrl(ins));
    check("decode_busy", busy, 1);
    zero_in = zr;
    start = (sp == 2);
    @(negedge clk);
    start = 1'b0;
    off = int'($signed(ins[5:0]));
    if (ins[8:6] == 3'b111) mhalt = 1'b1;
    else if (ins[8:6] == 3'b110 && !zr) mpc = wrap(mpc + off, W);
    else mpc = wrap(mpc + 1, W);
    if (mhalt) begin
      check("halt_done", done, 1);
      check("halt_busy", busy, 0);
      check("halt_addr", instr_addr, mpc);
    end
  endtask

  task automatic restart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mpc = 0;
    mhalt = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 9'b111_000_000;
    for (int i = 0; i < 16; i++) rom4[i] = 9'b111_000_000;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ctrl", ctrl_all, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", instr_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // MOVI r2,5 then HALT
    rom[0] = 9'b001_010_101; rom[1] = 9'b111_000_000;
    restart();
    run_instr(0, 0);
    run_instr(0, 0);
    @(negedge clk);
    check("halt_hold_addr", instr_addr, 1);
    check("halt_hold_done", done, 1);

    // LD r1,[r3]; start during FETCH must not disturb the run
    rom[0] = 9'b010_001_011;
    restart();
    run_instr(0, 1);
    run_instr(0, 0);

    // BNZ at pc=5 with offset -3: taken once, then falls through to HALT at 6
    rom[0] = 9'b000_001_010; rom[1] = 9'b100_011_001; rom[2] = 9'b101_010_011;
    rom[3] = 9'b011_100_110; rom[4] = 9'b001_111_111; rom[5] = 9'b110_111101;
    rom[6] = 9'b111_000_000;
    restart();
    for (int k = 0; k < 5; k++) run_instr(0, 0);
    run_instr(0, 0);
    for (int k = 0; k < 3; k++) run_instr(0, 2);
    run_instr(1, 0);
    run_instr(0, 0);

    // Reset during DECODE of ADD aborts the write strobe immediately
    rom[0] = 9'b100_001_010;
    restart();
    @(negedge clk);
    check("add_we", write_enable, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_we", write_enable, 0);
    check("abort_busy", busy, 0);
    check("abort_addr", instr_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_done", done, 0);
    check("post_rst_addr", instr_addr, 0);

    // PC wrap on a 4-bit PC: 0 -> 15 (offset -1) -> 1 (offset +2) -> HALT
    rom4[0] = 9'b110_111111; rom4[15] = 9'b110_000010; rom4[1] = 9'b111_000_000;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    check("w4_addr0", addr4, 0);
    repeat (2) @(negedge clk);
    check("w4_addr15", addr4, 15);
    repeat (2) @(negedge clk);
    check("w4_addr1", addr4, 1);
    repeat (2) @(negedge clk);
    check("w4_done", s_done, 1);
    check("w4_addr_hold", addr4, 1);

    // Random program with random zero flag and stray start pulses
    for (int i = 0; i < 1024; i++) rom[i] = 9'($urandom);
    restart();
    for (int it = 0; it < 150; it++) begin
      if (mhalt) begin
        check("rand_halt_done", done, 1);
        restart();
      end else begin
        run_instr(1'($urandom), ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
